// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button gesture classifier.
package button_pkg;

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} btn_state_t;

  localparam int unsigned DEF_LONG_CYC   = 50_000_000;
  localparam int unsigned DEF_DCLICK_CYC = 15_000_000;

  // Counter must reach the larger threshold; one spare bit keeps the compare unsigned-safe.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers the button level and flags its rising/falling edges (combinational vs. the register).
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/button_event_fsm.sv
// Classifies debounced button gestures into press/release/short/long/double one-cycle pulses.
module button_event_fsm
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYC   = DEF_LONG_CYC,
  parameter int unsigned DCLICK_CYC = DEF_DCLICK_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_db,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic long_press,
  output logic double_click
);

  localparam int unsigned CNT_W = cnt_width(LONG_CYC, DCLICK_CYC);
  localparam logic [CNT_W-1:0] LONG_THR   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLICK_THR = CNT_W'(DCLICK_CYC - 1);

  logic rise;
  logic fall;

  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             short_nxt, long_nxt, dbl_nxt;

  edge_detect u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pb_db),
    .q    (held),
    .rise (rise),
    .fall (fall)
  );

  // Next state; a release beats the long threshold and a re-press beats the click timeout.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    dbl_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_nxt = WAIT2;
          cnt_nxt   = '0;
        end else if (cnt == LONG_THR) begin
          state_nxt = LONG;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT2: begin
        if (rise) begin
          state_nxt = PRESS2;
          dbl_nxt   = 1'b1;
        end else if (cnt == DCLICK_THR) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESS2, LONG: begin
        if (fall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      long_press    <= 1'b0;
      double_click  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_click   <= short_nxt;
      long_press    <= long_nxt;
      double_click  <= dbl_nxt;
    end
  end

endmodule
